// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//   Data-memory responder for the CPU MEM-stage initiator. Holds a word-organised
//   array, inserts WAIT_CYC wait states per access, pulses DM_ready on completion
//   and drives DM_busy to stall the pipeline while an access is outstanding.
//
//   Optional feature macro: DM_RESP_ERR_EN
//     defined   : DM_err port present; misaligned / out-of-range accesses are
//                 flagged and suppressed (no write, DM_out unchanged).
//     undefined : addr[1:0] ignored, upper address bits wrap modulo DEPTH.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   DM_read   in   read request, held until DM_ready
//   DM_write  in   write request, held until DM_ready (wins over DM_read)
//   DM_addr   in   byte address
//   DM_in     in   write data
//   DM_out    out  registered read data, held until the next completed read
//   DM_ready  out  one-cycle completion pulse
//   DM_busy   out  combinational stall request
//   DM_err    out  registered access error, valid with DM_ready (DM_RESP_ERR_EN)
// -----------------------------------------------------------------------------
module dm_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_read,
    input  logic              DM_write,
    input  logic [ADDR_W-1:0] DM_addr,
    input  logic [DATA_W-1:0] DM_in,
    output logic [DATA_W-1:0] DM_out,
    output logic              DM_ready,
    output logic              DM_busy
`ifdef DM_RESP_ERR_EN
    ,
    output logic              DM_err
`endif
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam bit         NO_WAIT  = (WAIT_CYC == 0);
    localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_wr;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req;
    logic              w_idle;
    logic              w_enter_resp;
    logic              w_wr;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_data;
    logic              w_bad;
    logic              w_commit;

    assign w_req  = DM_read | DM_write;
    assign w_idle = (r_state == S_IDLE);

    // With WAIT_CYC==0 the array is accessed on the same edge that accepts the
    // request, so the live inputs are used instead of the not-yet-latched copy.
    assign w_enter_resp = (w_idle && w_req && NO_WAIT) ||
                          (r_state == S_WAIT && r_cnt == 4'd0);
    assign w_wr   = w_idle ? DM_write               : r_wr;
    assign w_idx  = w_idle ? DM_addr[IDX_W+1:2]     : r_idx;
    assign w_data = w_idle ? DM_in                  : r_data;

`ifdef DM_RESP_ERR_EN
    logic r_bad;
    logic w_bad_now;
    assign w_bad_now = (|DM_addr[1:0]) | (|DM_addr[ADDR_W-1:IDX_W+2]);
    assign w_bad     = w_idle ? w_bad_now : r_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bad  <= 1'b0;
            DM_err <= 1'b0;
        end else begin
            if (w_idle && w_req) r_bad <= w_bad_now;
            DM_err <= w_enter_resp & w_bad;
        end
    end
`else
    logic w_unused;
    assign w_unused = (^DM_addr[ADDR_W-1:IDX_W+2]) ^ (^DM_addr[1:0]);
    assign w_bad    = 1'b0;
`endif

    assign w_commit = w_enter_resp & ~w_bad;

    assign DM_busy = (w_idle & w_req) | (r_state == S_WAIT);

    // Array is not reset; rst gating stops a zero-wait write during reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_wr && !rst) r_mem[w_idx] <= w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_idx    <= '0;
            r_data   <= '0;
            DM_out   <= '0;
            DM_ready <= 1'b0;
        end else begin
            DM_ready <= w_enter_resp;
            if (w_commit && !w_wr) DM_out <= r_mem[w_idx];

            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_wr   <= DM_write;
                        r_idx  <= DM_addr[IDX_W+1:2];
                        r_data <= DM_in;
                        r_cnt  <= CNT_INIT;
                        r_state <= NO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) r_state <= S_RESP;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
//   Directed bench for dm_responder. Instance 0 uses WAIT_CYC=2, instance 1
//   uses WAIT_CYC=0. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        err  [2];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYC(2)) u_dut0 (
        .clk(clk), .rst(rst), .DM_read(rd[0]), .DM_write(wr[0]),
        .DM_addr(addr[0]), .DM_in(din[0]), .DM_out(dout[0]),
        .DM_ready(rdy[0]), .DM_busy(busy[0])
`ifdef DM_RESP_ERR_EN
        , .DM_err(err[0])
`endif
    );

    dm_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_CYC(0)) u_dut1 (
        .clk(clk), .rst(rst), .DM_read(rd[1]), .DM_write(wr[1]),
        .DM_addr(addr[1]), .DM_in(din[1]), .DM_out(dout[1]),
        .DM_ready(rdy[1]), .DM_busy(busy[1])
`ifdef DM_RESP_ERR_EN
        , .DM_err(err[1])
`endif
    );

`ifndef DM_RESP_ERR_EN
    initial begin
        err[0] = 1'b0;
        err[1] = 1'b0;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one access starting at a falling edge in IDLE, holds it until
    // DM_ready, then drops it and steps through the following IDLE cycle.
    task automatic access(input int s, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] q,
                          output logic b_req, output logic b_resp,
                          output logic e, output logic rdy_after);
        rd[s] = r; wr[s] = w; addr[s] = a; din[s] = d;
        #1 b_req = busy[s];
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rdy[s]) break;
        end
        q      = dout[s];
        b_resp = busy[s];
        e      = err[s];
        rd[s] = 1'b0; wr[s] = 1'b0;
        @(negedge clk);
        rdy_after = rdy[s];
    endtask

    int          lat;
    logic [31:0] q;
    logic        b_req, b_resp, e, ra;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out0",  dout[0], 32'h0);
        chk("rst_rdy0",  {31'b0, rdy[0]},  32'h0);
        chk("rst_busy0", {31'b0, busy[0]}, 32'h0);
        chk("rst_out1",  dout[1], 32'h0);
        rst = 1'b0;

        // Test 1: write then read, WAIT_CYC=2
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, q, b_req, b_resp, e, ra);
        chk("t1_wr_lat",   lat, 32'd3);
        chk("t1_wr_busyq", {31'b0, b_req},  32'h1);
        chk("t1_wr_busyr", {31'b0, b_resp}, 32'h0);
        chk("t1_wr_dout",  q, 32'h0);
        chk("t1_wr_err",   {31'b0, e},  32'h0);
        chk("t1_wr_pulse", {31'b0, ra}, 32'h0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, q, b_req, b_resp, e, ra);
        chk("t1_rd_lat",  lat, 32'd3);
        chk("t1_rd_dout", q, 32'hDEADBEEF);

        // Test 2: reset in WAIT aborts a write
        access(0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, lat, q, b_req, b_resp, e, ra);
        wr[0] = 1'b1; addr[0] = 32'h20; din[0] = 32'h1234;
        @(negedge clk);
        chk("t2_busy_wait", {31'b0, busy[0]}, 32'h1);
        rst = 1'b1;
        wr[0] = 1'b0;
        #1;
        chk("t2_rst_out",  dout[0], 32'h0);
        chk("t2_rst_rdy",  {31'b0, rdy[0]},  32'h0);
        chk("t2_rst_busy", {31'b0, busy[0]}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, q, b_req, b_resp, e, ra);
        chk("t2_rd_old", q, 32'h0BADF00D);

        // Test 3: read and write together -> write wins, DM_out unchanged
        access(0, 1'b1, 1'b1, 32'h8, 32'h55, lat, q, b_req, b_resp, e, ra);
        chk("t3_lat",  lat, 32'd3);
        chk("t3_dout", q, 32'h0BADF00D);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, lat, q, b_req, b_resp, e, ra);
        chk("t3_rd", q, 32'h55);

        // Test 5: out-of-range write
        access(0, 1'b0, 1'b1, 32'h0, 32'h11, lat, q, b_req, b_resp, e, ra);
        access(0, 1'b0, 1'b1, 32'h1000, 32'hA5, lat, q, b_req, b_resp, e, ra);
        chk("t5_lat", lat, 32'd3);
`ifdef DM_RESP_ERR_EN
        chk("t5_err", {31'b0, e}, 32'h1);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, q, b_req, b_resp, e, ra);
        chk("t5_rd0", q, 32'h11);
        // Test 6: misaligned read flagged, DM_out unchanged
        access(0, 1'b1, 1'b0, 32'h3, 32'h0, lat, q, b_req, b_resp, e, ra);
        chk("t6_lat",  lat, 32'd3);
        chk("t6_err",  {31'b0, e}, 32'h1);
        chk("t6_dout", q, 32'h11);
`else
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, q, b_req, b_resp, e, ra);
        chk("t5_wrap", q, 32'hA5);
        // Low address bits ignored: 0x13 selects word 4 (0x10)
        access(0, 1'b1, 1'b0, 32'h13, 32'h0, lat, q, b_req, b_resp, e, ra);
        chk("t6_lowbits", q, 32'hDEADBEEF);
`endif

        // Test 4: WAIT_CYC=0, back-to-back accesses
        access(1, 1'b0, 1'b1, 32'h0, 32'h77, lat, q, b_req, b_resp, e, ra);
        chk("t4_wr_lat", lat, 32'd1);
        access(1, 1'b0, 1'b1, 32'h4, 32'h88, lat, q, b_req, b_resp, e, ra);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, lat, q, b_req, b_resp, e, ra);
        chk("t4_rd0_lat",   lat, 32'd1);
        chk("t4_rd0_busyq", {31'b0, b_req},  32'h1);
        chk("t4_rd0_busyr", {31'b0, b_resp}, 32'h0);
        chk("t4_rd0_dout",  q, 32'h77);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, lat, q, b_req, b_resp, e, ra);
        chk("t4_rd1_lat",   lat, 32'd1);
        chk("t4_rd1_dout",  q, 32'h88);
        chk("t4_rd1_pulse", {31'b0, ra}, 32'h0);
        chk("t4_idle_busy", {31'b0, busy[1]}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
